// File: rtl/seq_divider_param_if.sv
// Operand/result bundle between an ALU-side controller and the sequential divider.
// Handshake: the controller raises start for one cycle while the divider is idle
// (busy=0); operands and signed_mode are captured on that rising edge. The divider
// answers with a single-cycle done pulse; quotient, remainder and div_by_zero are
// valid from that cycle and held until the next done. start while busy is ignored.
interface seq_divider_param_if #(
   parameter int DW = 32,
   parameter int VW = 16
);
   logic          start;
   logic          signed_mode;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_divider_param.sv
// Iterative restoring divider, one quotient bit per cycle, unsigned or signed.
// Signed operands are reduced to magnitudes, divided, then sign-corrected in FIX.
// Normal latency is DW+1 cycles from the accepting edge; a zero divisor takes 1.
module seq_divider_param #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic                clk,
   input  logic                rst,
   seq_divider_param_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dvd_r;     // dividend magnitude, becomes quotient magnitude bit by bit
   logic [VW-1:0] dvs_r;     // divisor magnitude
   logic [VW-1:0] rem_r;     // partial remainder
   logic          neg_q;
   logic          neg_r;
   logic [DW-1:0] q_r;
   logic [VW-1:0] r_r;
   logic          busy_r;
   logic          done_r;
   logic          dbz_r;

   logic          a_neg;
   logic          b_neg;
   logic [DW-1:0] a_mag;
   logic [VW-1:0] b_mag;
   logic [VW:0]   shifted;
   logic [VW:0]   trial;
   logic          q_bit;

   // Operand magnitudes and the trial subtraction of the current restoring step
   always_comb begin
      a_neg   = bus.signed_mode & bus.dividend[DW-1];
      b_neg   = bus.signed_mode & bus.divisor[VW-1];
      a_mag   = a_neg ? (DW'(0) - bus.dividend) : bus.dividend;
      b_mag   = b_neg ? (VW'(0) - bus.divisor) : bus.divisor;
      shifted = {rem_r, dvd_r[DW-1]};
      trial   = shifted - {1'b0, dvs_r};
      // Partial remainder is always below the divisor, so bit VW of trial is a clean borrow
      q_bit   = ~trial[VW];
   end

   // Control FSM and datapath registers; results only change on done edges or reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         dvd_r  <= '0;
         dvs_r  <= '0;
         rem_r  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         q_r    <= '0;
         r_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  dvs_r  <= b_mag;
                  rem_r  <= '0;
                  busy_r <= 1'b1;
                  if (bus.divisor == '0) begin
                     // Raw dividend kept so its low bits can be returned as remainder
                     dvd_r <= bus.dividend;
                     state <= DONE;
                  end else begin
                     dvd_r <= a_mag;
                     cnt   <= CW'(DW - 1);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem_r <= q_bit ? trial[VW-1:0] : shifted[VW-1:0];
               dvd_r <= {dvd_r[DW-2:0], q_bit};
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - 1'b1;
            end
            FIX: begin
               q_r    <= neg_q ? (DW'(0) - dvd_r) : dvd_r;
               r_r    <= neg_r ? (VW'(0) - rem_r) : rem_r;
               dbz_r  <= 1'b0;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            DONE: begin
               q_r    <= '1;
               r_r    <= dvd_r[VW-1:0];
               dbz_r  <= 1'b1;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.quotient    = q_r;
   assign bus.remainder   = r_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign dbg_state       = state;
endmodule
